axi_stream_header_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single header-insert port of axi_stream_insert_header among NUM_SRC header requesters.

---
 rtl/axi_stream_header_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_axi_stream_header_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_header_arbiter.sv
// -----------------------------------------------------------------------------
// axi_stream_header_arbiter
//
// Shares the single header-insert port of axi_stream_insert_header among
// NUM_SRC header requesters. A round-robin pick in IDLE grants one source. Its
// header is captured and offered on the insert interface. Arbitration then
// stays locked until the downstream packet carrying that header completes
// (valid_out & ready_out & last_out). This gives exactly one header per
// packet, delivered in grant order.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid/ready  per-source header handshake (req_ready is one-hot or zero,
//                    and is only ever asserted in IDLE)
//   req_data/keep    per-source header, source i at [i*W +: W]
//   valid_insert,    registered header presented to the inserter;
//   data_insert,     held stable until ready_insert
//   keep_insert
//   ready_insert     inserter accepts the header
//   valid_out,       monitored inserter output; a last-beat handshake
//   ready_out,       ends the packet that owns the current grant
//   last_out
//   grant_id         source owning the current header/packet
//   busy             header offered or packet in flight
//   err_keep         one-cycle pulse when an illegal header keep is dropped
//   hdr_cnt          number of headers delivered, saturating
// -----------------------------------------------------------------------------
module axi_stream_header_arbiter #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int NUM_SRC      = 4,
   parameter int CNT_WD       = 16,
   localparam int ID_WD       = $clog2(NUM_SRC)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_SRC-1:0]              req_valid,
   input  logic [NUM_SRC*DATA_WD-1:0]      req_data,
   input  logic [NUM_SRC*DATA_BYTE_WD-1:0] req_keep,
   output logic [NUM_SRC-1:0]              req_ready,
   output logic                            valid_insert,
   output logic [DATA_WD-1:0]              data_insert,
   output logic [DATA_BYTE_WD-1:0]         keep_insert,
   input  logic                            ready_insert,
   input  logic                            valid_out,
   input  logic                            ready_out,
   input  logic                            last_out,
   output logic [ID_WD-1:0]                grant_id,
   output logic                            busy,
   output logic                            err_keep,
   output logic [CNT_WD-1:0]               hdr_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_OFFER, S_WAIT_PKT} state_t;

   state_t                  state_q, state_d;
   logic [ID_WD-1:0]        rr_ptr_q, rr_ptr_d;
   logic [ID_WD-1:0]        grant_id_q, grant_id_d;
   logic [DATA_WD-1:0]      data_q, data_d;
   logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;
   logic                    busy_q, busy_d;
   logic [CNT_WD-1:0]       cnt_q, cnt_d;

   logic                    win_found;
   logic [ID_WD-1:0]        win_id;
   logic [DATA_WD-1:0]      sel_data;
   logic [DATA_BYTE_WD-1:0] sel_keep;
   logic                    keep_legal;
   logic                    pkt_done;

   // Increment a source index with wrap at NUM_SRC (which need not be a
   // power of two).
   function automatic logic [ID_WD-1:0] wrap_inc(input logic [ID_WD-1:0] id);
      if (id == ID_WD'(NUM_SRC - 1)) return '0;
      return id + ID_WD'(1);
   endfunction

   // Round-robin search. Walk the offsets from the far end down to zero, so
   // the last hit written is the one closest to rr_ptr.
   always_comb begin : arb_search
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_id    = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = ID_WD'(idx);
         end
      end
   end

   assign sel_data = req_data[int'(win_id)*DATA_WD +: DATA_WD];
   assign sel_keep = req_keep[int'(win_id)*DATA_BYTE_WD +: DATA_BYTE_WD];

   // A legal keep is a nonzero run of ones starting at bit 0. Adding one to
   // such a value carries out of every set bit, so the AND is zero.
   assign keep_legal = (sel_keep != '0) &&
                       ((sel_keep & (sel_keep + DATA_BYTE_WD'(1))) == '0);

   assign pkt_done = valid_out & ready_out & last_out;

   always_comb begin : next_state
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      data_d     = data_q;
      keep_d     = keep_q;
      valid_d    = valid_q;
      err_d      = 1'b0;
      cnt_d      = cnt_q;
      req_ready  = '0;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               req_ready[win_id] = 1'b1;
               if (keep_legal) begin
                  state_d    = S_OFFER;
                  grant_id_d = win_id;
                  data_d     = sel_data;
                  keep_d     = sel_keep;
                  valid_d    = 1'b1;
               end else begin
                  // Drop the bad header. Move past the offender so that it
                  // cannot starve the other sources.
                  err_d    = 1'b1;
                  rr_ptr_d = wrap_inc(win_id);
               end
            end
         end
         S_OFFER: begin
            if (ready_insert) begin
               state_d = S_WAIT_PKT;
               valid_d = 1'b0;
               if (cnt_q != '1) cnt_d = cnt_q + CNT_WD'(1);
            end
         end
         S_WAIT_PKT: begin
            // A last beat seen in IDLE or OFFER belongs to an earlier packet.
            // Only a last beat seen here releases the lock.
            if (pkt_done) begin
               state_d  = S_IDLE;
               rr_ptr_d = wrap_inc(grant_id_q);
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         data_q     <= '0;
         keep_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         data_q     <= data_d;
         keep_q     <= keep_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
      end
   end

   assign valid_insert = valid_q;
   assign data_insert  = data_q;
   assign keep_insert  = keep_q;
   assign grant_id     = grant_id_q;
   assign busy         = busy_q;
   assign err_keep     = err_q;
   assign hdr_cnt      = cnt_q;

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for axi_stream_header_arbiter.
//
// A behavioural model runs throughout the whole run. It is sampled on every
// falling edge and compared with every DUT output. Directed scenarios add
// literal expectations that pin the model down. A randomized phase follows.
// The counter is built 5 bits wide here so that saturation can be reached.
// -----------------------------------------------------------------------------
module tb_axi_stream_header_arbiter;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int N  = 4;
   localparam int CW = 5;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N*BW-1:0] req_keep = '0;
   logic [N-1:0]    req_ready;
   logic            valid_insert;
   logic [DW-1:0]   data_insert;
   logic [BW-1:0]   keep_insert;
   logic            ready_insert = 1'b0;
   logic            valid_out = 1'b0;
   logic            ready_out = 1'b0;
   logic            last_out = 1'b0;
   logic [IW-1:0]   grant_id;
   logic            busy;
   logic            err_keep;
   logic [CW-1:0]   hdr_cnt;

   axi_stream_header_arbiter #(
      .DATA_WD(DW), .DATA_BYTE_WD(BW), .NUM_SRC(N), .CNT_WD(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep),
      .req_ready(req_ready),
      .valid_insert(valid_insert), .data_insert(data_insert),
      .keep_insert(keep_insert), .ready_insert(ready_insert),
      .valid_out(valid_out), .ready_out(ready_out), .last_out(last_out),
      .grant_id(grant_id), .busy(busy), .err_keep(err_keep), .hdr_cnt(hdr_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = waiting for a request, 1 = header offered, 2 = packet running
   int            m_phase, m_ptr, m_gid, m_cnt;
   logic [DW-1:0] m_data;
   logic [BW-1:0] m_keep;
   bit            m_err;

   function automatic bit keep_ok(input logic [BW-1:0] k);
      for (int n = 1; n <= BW; n++)
         if (int'(k) == (1 << n) - 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   always @(negedge clk) begin
      int           w;
      logic [N-1:0] exp_rdy;
      if (!rst_n) begin
         m_phase = 0; m_ptr = 0; m_gid = 0; m_cnt = 0;
         m_data = '0; m_keep = '0; m_err = 1'b0;
      end
      w = pick(req_valid, m_ptr);
      exp_rdy = '0;
      if (m_phase == 0 && w >= 0) exp_rdy[w] = 1'b1;
      check("m_req_ready",    64'(req_ready),    64'(exp_rdy));
      check("m_valid_insert", 64'(valid_insert), 64'(m_phase == 1));
      check("m_data_insert",  64'(data_insert),  64'(m_data));
      check("m_keep_insert",  64'(keep_insert),  64'(m_keep));
      check("m_grant_id",     64'(grant_id),     64'(m_gid));
      check("m_busy",         64'(busy),         64'(m_phase != 0));
      check("m_err_keep",     64'(err_keep),     64'(m_err));
      check("m_hdr_cnt",      64'(hdr_cnt),      64'(m_cnt));
      if (rst_n) begin
         m_err = 1'b0;
         if (m_phase == 0) begin
            if (w >= 0) begin
               if (keep_ok(req_keep[w*BW +: BW])) begin
                  m_gid = w; m_data = req_data[w*DW +: DW];
                  m_keep = req_keep[w*BW +: BW]; m_phase = 1;
               end else begin
                  m_err = 1'b1; m_ptr = (w + 1) % N;
               end
            end
         end else if (m_phase == 1) begin
            if (ready_insert) begin
               m_phase = 2;
               if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            end
         end else begin
            if (valid_out && ready_out && last_out) begin
               m_phase = 0; m_ptr = (m_gid + 1) % N;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk); #1;
   endtask

   task automatic set_src(input int i, input logic [DW-1:0] d, input logic [BW-1:0] k);
      req_data[i*DW +: DW] = d;
      req_keep[i*BW +: BW] = k;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0; req_valid = '0; ready_insert = 1'b0;
      valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   // Drive the last-beat handshake until the lock is released, with a bound.
   task automatic finish_pkt(input string name);
      bit done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         tick();
         valid_out = 1'b1; ready_out = 1'b1; last_out = 1'b1; ready_insert = 1'b1;
         smp();
         if (!busy) done = 1'b1;
      end
      tick();
      valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0; ready_insert = 1'b0;
      check({name, "_released"}, 64'(done), 64'(1));
   endtask

   int seq [8];
   int nseq;
   int ndel;

   initial begin
      // ---- 1: single source 0 ----
      do_reset();
      smp();
      check("rst_valid_insert", 64'(valid_insert), 64'(0));
      check("rst_busy",         64'(busy),         64'(0));
      check("rst_hdr_cnt",      64'(hdr_cnt),      64'(0));
      check("rst_grant_id",     64'(grant_id),     64'(0));
      check("rst_data",         64'(data_insert),  64'(0));
      check("rst_err",          64'(err_keep),     64'(0));
      check("rst_req_ready",    64'(req_ready),    64'(0));
      tick();
      set_src(0, 32'hA5A5_0001, 4'b0011); req_valid = 4'b0001; ready_insert = 1'b1;
      smp();
      check("t1_req_ready", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid = '0;
      smp();
      check("t1_valid",  64'(valid_insert), 64'(1));
      check("t1_data",   64'(data_insert),  64'(32'hA5A5_0001));
      check("t1_keep",   64'(keep_insert),  64'(4'b0011));
      tick();
      smp();
      check("t1_valid_drop", 64'(valid_insert), 64'(0));
      check("t1_hdr_cnt",    64'(hdr_cnt),      64'(1));
      check("t1_busy",       64'(busy),         64'(1));
      finish_pkt("t1");

      // ---- 2: all sources, 8 packets, round-robin order ----
      do_reset();
      for (int i = 0; i < N; i++) set_src(i, 32'hC0DE_0000 + i, 4'b1111);
      req_valid = 4'b1111; ready_insert = 1'b1; valid_out = 1'b1; ready_out = 1'b1;
      nseq = 0;
      for (int c = 0; c < 400 && nseq < 8; c++) begin
         smp();
         if (busy) check("t2_no_ready_busy", 64'(req_ready), 64'(0));
         if (valid_insert) begin seq[nseq] = int'(grant_id); nseq++; end
         tick();
         last_out = ($urandom_range(0, 3) == 0);
      end
      check("t2_count", 64'(nseq), 64'(8));
      for (int i = 0; i < 8; i++) check($sformatf("t2_grant%0d", i), 64'(seq[i]), 64'(i % 4));
      req_valid = '0;
      finish_pkt("t2");

      // ---- 3: ready_insert held low in OFFER ----
      tick();
      set_src(1, 32'h1111_2222, 4'b0111); req_valid = 4'b0010; ready_insert = 1'b0;
      smp();
      check("t3_req_ready", 64'(req_ready), 64'(4'b0010));
      tick();
      set_src(1, 32'hDEAD_BEEF, 4'b1111);
      for (int c = 0; c < 5; c++) begin
         smp();
         check("t3_valid_held", 64'(valid_insert), 64'(1));
         check("t3_data_held",  64'(data_insert),  64'(32'h1111_2222));
         check("t3_keep_held",  64'(keep_insert),  64'(4'b0111));
         check("t3_no_ready",   64'(req_ready),    64'(0));
         tick();
      end
      ready_insert = 1'b1; req_valid = '0;
      tick();
      ready_insert = 1'b0;
      smp();
      check("t3_valid_drop", 64'(valid_insert), 64'(0));
      check("t3_hdr_cnt",    64'(hdr_cnt),      64'(9));
      finish_pkt("t3");

      // ---- 4: illegal keep from source 2 ----
      tick();
      set_src(2, 32'hBAD0_0002, 4'b0101); req_valid = 4'b0100;
      smp();
      check("t4_req_ready", 64'(req_ready), 64'(4'b0100));
      tick();
      set_src(2, 32'h0000_0002, 4'b0001);
      set_src(0, 32'h0000_0000, 4'b0001);
      set_src(3, 32'h3333_3333, 4'b1111);
      req_valid = 4'b1101;
      smp();
      check("t4_err",        64'(err_keep),     64'(1));
      check("t4_valid",      64'(valid_insert), 64'(0));
      check("t4_busy",       64'(busy),         64'(0));
      check("t4_next_ready", 64'(req_ready),    64'(4'b1000));
      tick();
      req_valid = '0;
      smp();
      check("t4_grant", 64'(grant_id),     64'(3));
      check("t4_data",  64'(data_insert),  64'(32'h3333_3333));
      check("t4_err_1", 64'(err_keep),     64'(0));

      // ---- 5: stray last in OFFER, then reset in WAIT_PKT ----
      tick();
      valid_out = 1'b1; ready_out = 1'b1; last_out = 1'b1;
      tick();
      valid_out = 1'b0; ready_out = 1'b0; last_out = 1'b0;
      smp();
      check("t5_offer_kept", 64'(valid_insert), 64'(1));
      check("t5_busy",       64'(busy),         64'(1));
      tick();
      ready_insert = 1'b1;
      tick();
      ready_insert = 1'b0;
      smp();
      check("t5_wait_busy", 64'(busy), 64'(1));
      tick();
      rst_n = 1'b0;
      smp();
      check("t5_rst_busy",  64'(busy),         64'(0));
      check("t5_rst_cnt",   64'(hdr_cnt),      64'(0));
      check("t5_rst_grant", 64'(grant_id),     64'(0));
      check("t5_rst_data",  64'(data_insert),  64'(0));
      check("t5_rst_keep",  64'(keep_insert),  64'(0));
      tick();
      rst_n = 1'b1; req_valid = 4'b1111;
      smp();
      check("t5_first_src0", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid = '0;
      finish_pkt("t5");

      // ---- 6: counter saturation ----
      do_reset();
      set_src(0, 32'h0600_0000, 4'b1111);
      req_valid = 4'b0001; ready_insert = 1'b1;
      valid_out = 1'b1; ready_out = 1'b1; last_out = 1'b1;
      ndel = 0;
      for (int c = 0; c < 300 && ndel < 34; c++) begin
         smp();
         if (valid_insert && ready_insert) ndel++;
         tick();
      end
      req_valid = '0;
      check("t6_delivered", 64'(ndel), 64'(34));
      finish_pkt("t6");
      smp();
      check("t6_saturated", 64'(hdr_cnt), 64'(5'h1F));

      // ---- randomized phase ----
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!rst_n) rst_n = 1'b1;
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0; req_valid = '0;
         end else begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
         end
         for (int i = 0; i < N; i++) begin
            logic [BW-1:0] k;
            if ($urandom_range(0, 4) == 0) k = BW'($urandom_range(0, (1 << BW) - 1));
            else k = BW'((1 << $urandom_range(1, BW)) - 1);
            set_src(i, $urandom, k);
         end
         ready_insert = $urandom_range(0, 1) == 1;
         valid_out    = $urandom_range(0, 3) != 0;
         ready_out    = $urandom_range(0, 3) != 0;
         last_out     = $urandom_range(0, 2) == 0;
      end
      tick();
      rst_n = 1'b1;
      smp();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
